// File: rtl/state_setting_pkg.sv
// Shared constants for the countdown setting editor: state codes, digit indices, per-digit limits.
package state_setting_pkg;
    localparam int BCD_W = 4;

    localparam logic [2:0] ST_COUNTING = 3'd0;
    localparam logic [2:0] ST_SETTING  = 3'd1;

    localparam logic [1:0] DIG_SEC0 = 2'd0;
    localparam logic [1:0] DIG_SEC1 = 2'd1;
    localparam logic [1:0] DIG_MIN0 = 2'd2;
    localparam logic [1:0] DIG_MIN1 = 2'd3;

    localparam logic [BCD_W-1:0] SEC0_MAX = 4'd9;
    localparam logic [BCD_W-1:0] SEC1_MAX = 4'd5;
    localparam logic [BCD_W-1:0] MIN0_MAX = 4'd9;

    typedef enum logic [1:0] {
        BTN_NEXT    = 2'd0,
        BTN_INC     = 2'd1,
        BTN_DEC     = 2'd2,
        BTN_CONFIRM = 2'd3
    } btn_e;

    function automatic logic [BCD_W-1:0] digit_max(input logic [1:0] idx,
                                                   input logic [BCD_W-1:0] max_min1);
        case (idx)
            DIG_SEC0: digit_max = SEC0_MAX;
            DIG_SEC1: digit_max = SEC1_MAX;
            DIG_MIN0: digit_max = MIN0_MAX;
            default:  digit_max = max_min1;
        endcase
    endfunction
endpackage

// File: rtl/state_setting_if.sv
// Button, state-code and result signals between the sequencer/display and the setting editor.
interface state_setting_if;
    logic        btn_next;
    logic        btn_inc;
    logic        btn_dec;
    logic        btn_confirm;
    logic [2:0]  currentState;
    logic [15:0] valueOut;
    logic [15:0] digitsOut;
    logic [3:0]  blinkMask;
    logic        finished;

    modport master (
        output btn_next, btn_inc, btn_dec, btn_confirm, currentState,
        input  valueOut, digitsOut, blinkMask, finished
    );

    modport slave (
        input  btn_next, btn_inc, btn_dec, btn_confirm, currentState,
        output valueOut, digitsOut, blinkMask, finished
    );
endinterface

// File: rtl/state_setting_button_edge.sv
// Raw button conditioning: 2-FF synchroniser, then a registered one-cycle pulse on the rising edge.
module button_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/state_setting.sv
// MM:SS countdown setting editor: per-digit BCD edit with cursor, blink highlight and confirm.
module state_setting
    import state_setting_pkg::*;
#(
    parameter logic [2:0]  stateID       = ST_SETTING,
    parameter logic [15:0] DEFAULT_VALUE = 16'h0100,
    parameter int          MAX_MIN1      = 5,
    parameter int          BLINK_DIV     = 12_500_000
) (
    input  logic           clk,
    input  logic           reset,
    state_setting_if.slave bus
);
    localparam int           CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [3:0] btn_raw;
    logic [3:0] press;

    assign btn_raw = {bus.btn_confirm, bus.btn_dec, bus.btn_inc, bus.btn_next};

    button_edge u_btn [3:0] (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_raw),
        .pulse (press)
    );

    logic [15:0]      value_q,    value_d;
    logic [1:0]       cursor_q,   cursor_d;
    logic             finished_q, finished_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             phase_q,    phase_d;
    logic [3:0]       mask_q,     mask_d;
    logic [2:0]       prev_state_q, prev_state_d;

    logic             active, entry, restart;
    logic [BCD_W-1:0] cur_digit, lim;

    always_comb begin
        value_d      = value_q;
        cursor_d     = cursor_q;
        finished_d   = finished_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        prev_state_d = bus.currentState;
        restart      = 1'b0;

        active    = (bus.currentState == stateID);
        entry     = active && (prev_state_q != stateID);
        cur_digit = value_q[{cursor_q, 2'b00} +: BCD_W];
        lim       = digit_max(cursor_q, BCD_W'(MAX_MIN1));

        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (!active) begin
            // Blink is frozen while away; entry restarts it anyway.
            finished_d = 1'b0;
            cnt_d      = cnt_q;
            phase_d    = phase_q;
        end else if (entry) begin
            cursor_d   = DIG_MIN1;
            finished_d = 1'b0;
            cnt_d      = '0;
            phase_d    = 1'b1;
        end else if (!finished_q) begin
            if (press[BTN_CONFIRM]) begin
                finished_d = (value_q != 16'h0000);
            end else if (press[BTN_NEXT]) begin
                cursor_d = cursor_q - 2'd1;
                restart  = 1'b1;
            end else if (press[BTN_INC]) begin
                value_d[{cursor_q, 2'b00} +: BCD_W] = (cur_digit >= lim) ? '0 : cur_digit + 4'd1;
                restart = 1'b1;
            end else if (press[BTN_DEC]) begin
                value_d[{cursor_q, 2'b00} +: BCD_W] = (cur_digit == '0) ? lim : cur_digit - 4'd1;
                restart = 1'b1;
            end
            if (restart) begin
                cnt_d   = '0;
                phase_d = 1'b1;
            end
        end

        // Mask built from next-state values so a cursor move shows on the same edge.
        mask_d = (active && !finished_d && phase_d) ? (4'b0001 << cursor_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q      <= DEFAULT_VALUE;
            cursor_q     <= DIG_MIN1;
            finished_q   <= 1'b0;
            cnt_q        <= '0;
            phase_q      <= 1'b1;
            mask_q       <= 4'b0000;
            prev_state_q <= 3'd0;
        end else begin
            value_q      <= value_d;
            cursor_q     <= cursor_d;
            finished_q   <= finished_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            mask_q       <= mask_d;
            prev_state_q <= prev_state_d;
        end
    end

    assign bus.valueOut  = value_q;
    assign bus.digitsOut = value_q;
    assign bus.blinkMask = mask_q;
    assign bus.finished  = finished_q;
endmodule

// File: tb/tb_state_setting.sv
// Directed bench for state_setting: expectations queued at stimulus time, popped when output is due.
module tb_state_setting;
    import state_setting_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    state_setting_if bus();

    state_setting #(
        .stateID       (3'd1),
        .DEFAULT_VALUE (16'h0100),
        .MAX_MIN1      (5),
        .BLINK_DIV     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [15:0] val;
        logic [3:0]  mask;
        logic        fin;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [15:0] v, input logic [3:0] m, input logic f);
        exp_t e;
        e.tag = tag; e.val = v; e.mask = m; e.fin = f;
        exp_q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: no expectation queued");
        end else begin
            e = exp_q.pop_front();
            assert ({bus.valueOut, bus.digitsOut, bus.blinkMask, bus.finished} ===
                    {e.val, e.val, e.mask, e.fin})
            else begin
                errors++;
                $error("FAIL %s: val=%h dig=%h mask=%b fin=%b, want val=%h mask=%b fin=%b",
                       e.tag, bus.valueOut, bus.digitsOut, bus.blinkMask, bus.finished,
                       e.val, e.mask, e.fin);
            end
        end
    endtask

    task automatic set_btn(input btn_e b, input logic lvl);
        case (b)
            BTN_NEXT:    bus.btn_next    = lvl;
            BTN_INC:     bus.btn_inc     = lvl;
            BTN_DEC:     bus.btn_dec     = lvl;
            default:     bus.btn_confirm = lvl;
        endcase
    endtask

    // Starts at a negedge; returns at the negedge after the register update (edge N+3).
    task automatic press(input btn_e b);
        set_btn(b, 1'b1);
        @(negedge clk);
        set_btn(b, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.btn_next = 0; bus.btn_inc = 0; bus.btn_dec = 0; bus.btn_confirm = 0;
        bus.currentState = 3'd1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        push("reset_state", 16'h0100, 4'b0000, 1'b0); check();
        reset = 1'b1;
        @(negedge clk);
        push("entry_after_reset", 16'h0100, 4'b1000, 1'b0); check();

        // Build 12:34 with cursor on sec1, then reset mid-edit
        press(BTN_INC); press(BTN_NEXT); press(BTN_INC); press(BTN_NEXT);
        repeat (3) press(BTN_INC);
        press(BTN_NEXT);
        repeat (4) press(BTN_INC);
        repeat (3) press(BTN_NEXT);
        push("build_1234", 16'h1234, 4'b0010, 1'b0); check();
        reset = 1'b0;
        @(negedge clk);
        push("reset_mid_edit", 16'h0100, 4'b0000, 1'b0); check();
        reset = 1'b1;
        @(negedge clk);
        push("entry_cursor3", 16'h0100, 4'b1000, 1'b0); check();

        // sec1 wrap both directions with no carry
        press(BTN_NEXT); press(BTN_DEC);
        push("dec_min0", 16'h0000, 4'b0100, 1'b0); check();
        press(BTN_NEXT);
        repeat (5) press(BTN_INC);
        push("set_0050", 16'h0050, 4'b0010, 1'b0); check();
        press(BTN_INC);
        push("inc_wrap_sec1", 16'h0000, 4'b0010, 1'b0); check();
        press(BTN_DEC);
        push("dec_wrap_sec1", 16'h0050, 4'b0010, 1'b0); check();

        // Held button: latency N+3 and exactly one increment
        bus.btn_inc = 1'b1;
        push("hold_before_n3", 16'h0050, 4'b0010, 1'b0);
        repeat (3) @(negedge clk);
        check();
        push("hold_at_n3", 16'h0000, 4'b0010, 1'b0);
        @(negedge clk);
        check();
        repeat (97) @(negedge clk);
        bus.btn_inc = 1'b0;
        repeat (5) @(negedge clk);
        press(BTN_NEXT);
        push("hold_one_inc", 16'h0000, 4'b0001, 1'b0); check();

        // confirm beats inc; edits ignored once finished
        press(BTN_NEXT); press(BTN_NEXT); press(BTN_INC);
        push("set_0100", 16'h0100, 4'b0100, 1'b0); check();
        bus.btn_confirm = 1'b1; bus.btn_inc = 1'b1;
        @(negedge clk);
        bus.btn_confirm = 1'b0; bus.btn_inc = 1'b0;
        repeat (3) @(negedge clk);
        push("confirm_over_inc", 16'h0100, 4'b0000, 1'b1); check();
        press(BTN_INC);
        push("edit_after_fin", 16'h0100, 4'b0000, 1'b1); check();

        // Leave / inactive presses / re-entry
        bus.currentState = 3'd0;
        @(negedge clk);
        push("leave_clears_fin", 16'h0100, 4'b0000, 1'b0); check();
        press(BTN_INC); press(BTN_NEXT); press(BTN_CONFIRM);
        push("inactive_ignored", 16'h0100, 4'b0000, 1'b0); check();
        bus.currentState = 3'd1;
        @(negedge clk);
        push("reenter", 16'h0100, 4'b1000, 1'b0); check();
        press(BTN_NEXT); press(BTN_DEC); press(BTN_CONFIRM);
        push("confirm_zero", 16'h0000, 4'b0000, 1'b0); check();
        press(BTN_INC); press(BTN_CONFIRM);
        push("confirm_nonzero", 16'h0100, 4'b0000, 1'b1); check();
        bus.currentState = 3'd0;
        @(negedge clk);
        push("leave2", 16'h0100, 4'b0000, 1'b0); check();
        bus.currentState = 3'd1;
        @(negedge clk);
        push("reenter2", 16'h0100, 4'b1000, 1'b0); check();

        // Blink on sec0 with BLINK_DIV=4
        repeat (3) press(BTN_NEXT);
        for (int k = 0; k < 12; k++) begin
            push($sformatf("blink_%0d", k), 16'h0100, ((k / 4) % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0);
            check();
            @(negedge clk);
        end
        press(BTN_NEXT);
        for (int j = 0; j < 5; j++) begin
            push($sformatf("next_restart_%0d", j), 16'h0100, (j < 4) ? 4'b1000 : 4'b0000, 1'b0);
            check();
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
